synapse_array: RTL and testbench

Parametrised synaptic-current engine for the SNN core, generalised to any bank count, lanes per bank, weight width and depth. For each presynaptic spike beat it reads one weight word from every weight BRAM bank, sums the signed weights of active lanes (optionally masked per bank) and emits a current. A weight-reset command rewrites every BRAM location with a programmable value. Sits between the spike source and the neuron block; weight storage is external single-port BRAMs.

---
 rtl/synapse_array_if.sv | 21 ++
 rtl/synapse_array.sv | 203 ++++++++++++++++++++
 tb/tb_synapse_array.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/synapse_array_if.sv
`default_nettype none
// ============================================================================
// Module   : synapse_array_if
// Brief    : Weight-BRAM bus between synapse_array (master) and its banks.
// Revision : 1.0
// ============================================================================
interface synapse_array_if #(
    parameter int NUM_BANK = 6,
    parameter int AWIDTH   = 9,
    parameter int BANK_W   = 64
);
    logic [NUM_BANK*AWIDTH-1:0] addr;
    logic [NUM_BANK-1:0]        ce;
    logic [NUM_BANK-1:0]        we;
    logic [NUM_BANK*BANK_W-1:0] d;
    logic [NUM_BANK*BANK_W-1:0] q;

    modport master (output addr, ce, we, d, input q);
    modport slave  (input addr, ce, we, d, output q);
endinterface
`default_nettype wire

// File: rtl/synapse_array.sv
`default_nettype none
// ============================================================================
// Module   : synapse_array
// Brief    : Per-beat signed sum of spiking synaptic weights over all BRAM
//            banks, plus a weight-reset sweep of every BRAM location.
// Config   : SYNAPSE_ARRAY_SAT_EN - clamp o_current when CUR_W < SUM_W.
// Revision : 1.0
// ============================================================================
module synapse_array #(
    parameter int NUM_BANK = 6,
    parameter int LANES    = 4,
    parameter int WEIGHT_W = 16,
    parameter int DEPTH    = 432,
    parameter int AWIDTH   = 9,
    parameter int CUR_W    = 25
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_run,
    input  logic                         i_wegt_rst,
    input  logic [WEIGHT_W-1:0]          i_rst_value,
    input  logic [NUM_BANK-1:0]          i_bank_mask,
    input  logic [NUM_BANK*LANES-1:0]    i_spike_bundle,
    input  logic                         i_valid,
    output logic [CUR_W-1:0]             o_current,
    output logic                         o_valid,
    output logic                         o_is_single_done,
    output logic                         o_done,
    output logic                         o_busy,
    synapse_array_if.master              bram
);

    localparam int NSPK  = NUM_BANK * LANES;
    localparam int SUM_W = WEIGHT_W + $clog2(NSPK);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [AWIDTH-1:0] c_last = AWIDTH'(DEPTH - 1);

    logic [2:0]          state_q, state_d;
    logic [AWIDTH-1:0]   cnt_q, cnt_d;
    logic [NUM_BANK-1:0] mask_q, mask_d;
    logic                run_q, run_d;
    logic [WEIGHT_W-1:0] rstv_q, rstv_d;

    logic                p1_valid_q;
    logic                p1_last_q;
    logic [NSPK-1:0]     p1_spk_q;
    logic [CUR_W-1:0]    o_current_q;
    logic                o_valid_q;
    logic                o_single_q;

    logic                w_run;
    logic                w_wrst;
    logic                w_beat;
    logic                w_last_addr;
    logic [AWIDTH-1:0]   w_addr;
    logic [NSPK-1:0]     w_mask_exp;
    logic signed [WEIGHT_W-1:0] w_wt;
    logic signed [SUM_W-1:0]    w_sum;
    logic [CUR_W-1:0]    w_cur;

    assign w_run       = (state_q == S_RUN);
    assign w_wrst      = (state_q == S_WRST);
    assign w_beat      = w_run && i_valid;
    assign w_last_addr = (cnt_q == c_last);
    assign w_addr      = (w_run || w_wrst) ? cnt_q : '0;

    generate
        for (genvar b = 0; b < NUM_BANK; b++) begin : g_mask
            assign w_mask_exp[b*LANES +: LANES] = {LANES{mask_q[b]}};
        end
    endgenerate

    // Control FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        run_d   = run_q;
        rstv_d  = rstv_q;
        case (state_q)
            S_IDLE: begin
                if (i_wegt_rst) begin
                    state_d = S_WRST;
                    cnt_d   = '0;
                    run_d   = 1'b0;
                    rstv_d  = i_rst_value;
                end else if (i_run) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    run_d   = 1'b1;
                    mask_d  = i_bank_mask;
                end
            end
            S_RUN: begin
                if (i_valid) begin
                    if (w_last_addr) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WRST: begin
                if (w_last_addr) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // A run waits for its last output; a weight reset waits one cycle
            // so the final write has landed before completion is reported.
            S_DRAIN: begin
                if (!run_q || o_single_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Weight sum over lanes selected by the registered, pre-masked spikes
    always_comb begin
        w_sum = '0;
        w_wt  = '0;
        for (int i = 0; i < NSPK; i++) begin
            w_wt = bram.q[i*WEIGHT_W +: WEIGHT_W];
            if (p1_spk_q[i]) begin
                w_sum = w_sum + SUM_W'(w_wt);
            end
        end
    end

    generate
        if (CUR_W >= SUM_W) begin : g_sext
            assign w_cur = CUR_W'(w_sum);
        end else begin : g_narrow
`ifdef SYNAPSE_ARRAY_SAT_EN
            localparam logic signed [SUM_W-1:0] c_sat_max =
                SUM_W'((longint'(1) <<< (CUR_W - 1)) - longint'(1));
            localparam logic signed [SUM_W-1:0] c_sat_min = ~c_sat_max;
            assign w_cur = (w_sum > c_sat_max) ? c_sat_max[CUR_W-1:0] :
                           (w_sum < c_sat_min) ? c_sat_min[CUR_W-1:0] :
                                                 w_sum[CUR_W-1:0];
`else
            logic w_unused_hi;
            assign w_unused_hi = ^w_sum[SUM_W-1:CUR_W];
            assign w_cur       = w_sum[CUR_W-1:0];
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mask_q      <= '0;
            run_q       <= 1'b0;
            rstv_q      <= '0;
            p1_valid_q  <= 1'b0;
            p1_last_q   <= 1'b0;
            p1_spk_q    <= '0;
            o_current_q <= '0;
            o_valid_q   <= 1'b0;
            o_single_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            run_q      <= run_d;
            rstv_q     <= rstv_d;
            p1_valid_q <= w_beat;
            p1_last_q  <= w_beat && w_last_addr;
            p1_spk_q   <= w_beat ? (i_spike_bundle & w_mask_exp) : '0;
            o_valid_q  <= p1_valid_q;
            o_single_q <= p1_last_q;
            if (p1_valid_q) begin
                o_current_q <= w_cur;
            end
        end
    end

    assign o_current        = o_current_q;
    assign o_valid          = o_valid_q;
    assign o_is_single_done = o_single_q;
    assign o_done           = (state_q == S_DONE);
    assign o_busy           = (state_q != S_IDLE);

    assign bram.addr = {NUM_BANK{w_addr}};
    assign bram.ce   = w_beat ? mask_q : (w_wrst ? {NUM_BANK{1'b1}} : '0);
    assign bram.we   = w_wrst ? {NUM_BANK{1'b1}} : '0;
    assign bram.d    = w_wrst ? {NSPK{rstv_q}} : '0;

endmodule
`default_nettype wire

// File: tb/tb_synapse_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_synapse_array
// Brief    : Scoreboard bench for synapse_array (CUR_W=25 and CUR_W=18 copies
//            sharing one BRAM model); honours SYNAPSE_ARRAY_SAT_EN.
// Revision : 1.0
// ============================================================================
module tb_synapse_array;

    localparam int NUM_BANK = 6;
    localparam int LANES    = 4;
    localparam int WEIGHT_W = 16;
    localparam int DEPTH    = 432;
    localparam int AWIDTH   = 9;
    localparam int CUR_W    = 25;
    localparam int CUR_W2   = 18;
    localparam int BANK_W   = LANES * WEIGHT_W;
    localparam int NSPK     = NUM_BANK * LANES;

    typedef struct {
        logic [CUR_W-1:0]  c1;
        logic [CUR_W2-1:0] c2;
        bit                last;
        int                cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                i_run = 1'b0;
    logic                i_wegt_rst = 1'b0;
    logic [WEIGHT_W-1:0] i_rst_value = '0;
    logic [NUM_BANK-1:0] i_bank_mask = '0;
    logic [NSPK-1:0]     i_spike_bundle = '0;
    logic                i_valid = 1'b0;

    logic [CUR_W-1:0]    o_current1;
    logic [CUR_W2-1:0]   o_current2;
    logic                o_valid1, o_valid2;
    logic                o_is_single_done1, o_is_single_done2;
    logic                o_done1, o_done2;
    logic                o_busy1, o_busy2;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    exp_t                sb[$];
    exp_t                mon_e;
    bit                  chk_bus = 1'b0;
    logic [NUM_BANK-1:0] exp_ce = '0;
    int                  exp_addr = 0;

    int                  bd_kind = 0;
    logic [WEIGHT_W-1:0] bd_val = '0;
    logic [BANK_W-1:0]   mem [NUM_BANK][DEPTH];
    logic [BANK_W-1:0]   bm_word;
    logic [WEIGHT_W-1:0] bm_wv;
    int                  bm_a;

    synapse_array_if #(.NUM_BANK(NUM_BANK), .AWIDTH(AWIDTH), .BANK_W(BANK_W)) bus1 ();
    synapse_array_if #(.NUM_BANK(NUM_BANK), .AWIDTH(AWIDTH), .BANK_W(BANK_W)) bus2 ();

    synapse_array #(
        .NUM_BANK(NUM_BANK), .LANES(LANES), .WEIGHT_W(WEIGHT_W),
        .DEPTH(DEPTH), .AWIDTH(AWIDTH), .CUR_W(CUR_W)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_wegt_rst(i_wegt_rst),
        .i_rst_value(i_rst_value), .i_bank_mask(i_bank_mask),
        .i_spike_bundle(i_spike_bundle), .i_valid(i_valid),
        .o_current(o_current1), .o_valid(o_valid1),
        .o_is_single_done(o_is_single_done1), .o_done(o_done1),
        .o_busy(o_busy1), .bram(bus1.master)
    );

    synapse_array #(
        .NUM_BANK(NUM_BANK), .LANES(LANES), .WEIGHT_W(WEIGHT_W),
        .DEPTH(DEPTH), .AWIDTH(AWIDTH), .CUR_W(CUR_W2)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_wegt_rst(i_wegt_rst),
        .i_rst_value(i_rst_value), .i_bank_mask(i_bank_mask),
        .i_spike_bundle(i_spike_bundle), .i_valid(i_valid),
        .o_current(o_current2), .o_valid(o_valid2),
        .o_is_single_done(o_is_single_done2), .o_done(o_done2),
        .o_busy(o_busy2), .bram(bus2.master)
    );

    assign bus2.q = bus1.q;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM banks (1-cycle read latency) with a one-cycle bulk preload port
    always @(posedge clk) begin
        if (bd_kind != 0) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    for (int l = 0; l < LANES; l++) begin
                        case (bd_kind)
                            1:       bm_wv = WEIGHT_W'(b*LANES + l - 8);
                            2:       bm_wv = WEIGHT_W'($urandom);
                            default: bm_wv = bd_val;
                        endcase
                        bm_word[l*WEIGHT_W +: WEIGHT_W] = bm_wv;
                    end
                    mem[b][a] <= bm_word;
                end
            end
        end else begin
            for (int b = 0; b < NUM_BANK; b++) begin
                if (bus1.ce[b]) begin
                    bm_a = int'(bus1.addr[b*AWIDTH +: AWIDTH]);
                    if (bm_a < DEPTH) begin
                        if (bus1.we[b]) mem[b][bm_a] <= bus1.d[b*BANK_W +: BANK_W];
                        else            bus1.q[b*BANK_W +: BANK_W] <= mem[b][bm_a];
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int wt(input int b, input int a, input int l);
        logic signed [WEIGHT_W-1:0] x;
        x = mem[b][a][l*WEIGHT_W +: WEIGHT_W];
        return int'(x);
    endfunction

    function automatic logic [CUR_W2-1:0] cvt2(input int s);
        int v;
        v = s;
`ifdef SYNAPSE_ARRAY_SAT_EN
        if (v > (1 << (CUR_W2-1)) - 1)  v = (1 << (CUR_W2-1)) - 1;
        else if (v < -(1 << (CUR_W2-1))) v = -(1 << (CUR_W2-1));
`endif
        return v[CUR_W2-1:0];
    endfunction

    // Output monitor: pops the scoreboard whenever a result is presented
    always @(negedge clk) begin
        if (o_valid1) begin
            if (sb.size() == 0) begin
                chk("out_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("cur1", o_current1, mon_e.c1);
                chk("cur2", o_current2, mon_e.c2);
                chk("valid2", o_valid2, 1);
                chk("latency", cyc, mon_e.cyc);
                chk("single_done", {o_is_single_done1, o_is_single_done2}, {2{mon_e.last}});
            end
        end else begin
            chk("idle_out", {o_valid2, o_is_single_done1, o_is_single_done2}, 0);
        end
        if (chk_bus) begin
            chk("ce", bus1.ce, exp_ce);
            chk("we", bus1.we, 0);
            if (exp_ce != 0) begin
                for (int b = 0; b < NUM_BANK; b++)
                    chk("addr", bus1.addr[b*AWIDTH +: AWIDTH], exp_addr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int kind, input logic [WEIGHT_W-1:0] val);
        step();
        bd_kind = kind;
        bd_val  = val;
        step();
        bd_kind = 0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_o1"}, {o_valid1, o_is_single_done1, o_done1, o_busy1}, 0);
        chk({nm, "_cur"}, {o_current1, o_current2}, 0);
        chk({nm, "_bus"}, {bus1.ce, bus1.we, bus1.addr, |bus1.d}, 0);
        chk({nm, "_o2"}, {o_valid2, o_done2, o_busy2}, 0);
    endtask

    task automatic wait_done(input string nm, input int exp_cyc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < DEPTH + 50 && !found; i++) begin
            @(negedge clk);
            if (o_done1) begin
                found = 1'b1;
                chk(nm, cyc, exp_cyc);
                chk({nm, "_busy"}, o_busy1, 1);
                chk({nm, "_done2"}, o_done2, 1);
            end
        end
        if (!found) chk({nm, "_timeout"}, 0, 1);
        @(negedge clk);
        chk({nm, "_idle"}, {o_busy1, o_done1}, 0);
    endtask

    task automatic do_run(input logic [NUM_BANK-1:0] mask, input int gap_mode,
                          input int spk_mode, input int abort_at);
        int beat, kl, s;
        bit tog;
        exp_t e;
        logic [NSPK-1:0] spk;
        step();
        i_run       = 1'b1;
        i_bank_mask = mask;
        beat = 0; kl = 0; tog = 1'b0;
        while (beat < DEPTH) begin
            step();
            i_run       = 1'b0;
            i_bank_mask = NUM_BANK'($urandom);
            if (beat == abort_at) begin
                reset_n = 1'b0;
                i_valid = 1'b0;
                exp_ce  = '0;
                sb.delete();
                @(negedge clk);
                chk_zero("abort");
                step();
                reset_n = 1'b1;
                return;
            end
            if ((gap_mode == 1 && tog) || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
                i_valid        = 1'b0;
                i_spike_bundle = NSPK'($urandom);
                exp_ce         = '0;
            end else begin
                case (spk_mode)
                    0:       spk = '1;
                    1:       spk = NSPK'(1 << 5);
                    default: spk = NSPK'($urandom);
                endcase
                i_valid        = 1'b1;
                i_spike_bundle = spk;
                exp_ce         = mask;
                exp_addr       = beat;
                s = 0;
                for (int b = 0; b < NUM_BANK; b++)
                    for (int l = 0; l < LANES; l++)
                        if (spk[b*LANES + l] && mask[b]) s += wt(b, beat, l);
                e.c1   = CUR_W'(s);
                e.c2   = cvt2(s);
                e.last = (beat == DEPTH - 1);
                e.cyc  = cyc + 2;
                sb.push_back(e);
                kl = cyc;
                beat++;
            end
            tog = ~tog;
        end
        step();
        i_valid = 1'b0;
        exp_ce  = '0;
        wait_done("run_done", kl + 3);
        chk("run_sb_empty", sb.size(), 0);
    endtask

    task automatic do_wrst(input logic [WEIGHT_W-1:0] val);
        int kc, bad;
        logic signed [WEIGHT_W-1:0] sv;
        step();
        chk_bus     = 1'b0;
        i_wegt_rst  = 1'b1;
        i_rst_value = val;
        i_run       = 1'b1;
        i_bank_mask = '1;
        kc = cyc;
        step();
        i_wegt_rst  = 1'b0;
        i_run       = 1'b0;
        i_rst_value = ~val;
        @(negedge clk);
        chk("wrst_busy", o_busy1, 1);
        wait_done("wrst_done", kc + DEPTH + 2);
        chk_bus = 1'b1;
        sv = val;
        for (int b = 0; b < NUM_BANK; b++) begin
            bad = 0;
            for (int a = 0; a < DEPTH; a++)
                for (int l = 0; l < LANES; l++)
                    if (wt(b, a, l) != int'(sv)) bad++;
            chk($sformatf("wrst_bank%0d", b), bad, 0);
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");
        step();
        reset_n = 1'b1;
        chk_bus = 1'b1;

        load(2, '0);
        do_wrst(16'h0001);
        do_run('1, 0, 0, -1);

        load(1, '0);
        do_run('1, 0, 1, -1);
        do_run(6'b111101, 1, 1, -1);

        load(2, '0);
        do_run(NUM_BANK'($urandom), 2, 2, -1);

        do_wrst(16'hFFF0);
        do_run(NUM_BANK'($urandom), 1, 2, -1);

        load(3, 16'h7FFF);
        do_run('1, 0, 0, -1);
        load(3, 16'h8000);
        do_run('1, 0, 0, -1);

        load(2, '0);
        do_run('1, 0, 2, 100);
        do_run(NUM_BANK'($urandom), 2, 2, -1);

        step();
        chk("final_sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
